// File: rtl/rv32imc_types.sv
// Shared execute-stage types: multiplier op encoding and the pipeline stage record.
package rv32imc_types;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_H   = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HU  = 2'b11
    } mul_op_t;

    // Default widths for the stage record; modules with other XLEN/TAG_W declare
    // a local struct with the same {valid, data, tag} field order.
    localparam int unsigned MUL_XLEN  = 32;
    localparam int unsigned MUL_TAG_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [MUL_XLEN-1:0]  data;
        logic [MUL_TAG_W-1:0] tag;
    } mul_stage_t;

    // Every op except MUL_LO returns the upper half of the product.
    function automatic logic mul_takes_high(mul_op_t op);
        return op != MUL_LO;
    endfunction

endpackage

// File: rtl/multiplier_core.sv
// Combinational (XLEN+1)x(XLEN+1) signed multiply with result-half select.
// Kept free of registers so synthesis can retime the downstream stages into it.
module multiplier_core
    import rv32imc_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  mul_op_t         op_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN:0]       a_ext;
    logic [XLEN:0]       b_ext;
    logic [2*XLEN+1:0]   a_wide;
    logic [2*XLEN+1:0]   b_wide;
    logic [2*XLEN+1:0]   prod;
    logic                unused_prod_top;

    // Extend operands per op signedness, then multiply; sign-extending both to the
    // full product width makes an unsigned multiply yield the two's complement result.
    always_comb begin
        a_ext    = {((op_i == MUL_H) || (op_i == MUL_HSU)) & op_a_i[XLEN-1], op_a_i};
        b_ext    = {(op_i == MUL_H) & op_b_i[XLEN-1], op_b_i};
        a_wide   = {{(XLEN+1){a_ext[XLEN]}}, a_ext};
        b_wide   = {{(XLEN+1){b_ext[XLEN]}}, b_ext};
        prod     = a_wide * b_wide;
        result_o = mul_takes_high(op_i) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    assign unused_prod_top = ^prod[2*XLEN+1:2*XLEN];

endmodule

// File: rtl/multiplier_pipelined.sv
// Fully pipelined M-extension multiplier: product and half-select in stage 0,
// then DEPTH plain register stages. One global advance signal freezes all stages
// under backpressure; flush drops every in-flight op.
// Optional build macro MULTIPLIER_PERF_EN adds saturating perf_ops/perf_stall counters.
module multiplier_pipelined
    import rv32imc_types::*;
#(
    parameter int unsigned XLEN  = 32,  // >= 8
    parameter int unsigned DEPTH = 2,   // 0..8
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef MULTIPLIER_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t [DEPTH:0] stage_q;
    stage_t [DEPTH:0] stage_d;
    logic [XLEN-1:0]  prod_res;
    logic             adv;

    multiplier_core #(
        .XLEN (XLEN)
    ) u_core (
        .op_a_i   (in_a),
        .op_b_i   (in_b),
        .op_i     (mul_op_t'(in_op)),
        .result_o (prod_res)
    );

    // Whole pipe moves only if the last slot is empty or being drained.
    assign adv       = ~stage_q[DEPTH].valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = stage_q[DEPTH].valid;
    assign out_data  = stage_q[DEPTH].data;
    assign out_tag   = stage_q[DEPTH].tag;

    // Next state: shift on advance (bubbles included), then flush kills all valids.
    always_comb begin
        stage_d = stage_q;
        if (adv) begin
            stage_d[0].valid = in_valid;
            stage_d[0].data  = prod_res;
            stage_d[0].tag   = in_tag;
            for (int i = 1; i <= int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i <= int'(DEPTH); i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    // Pipeline registers with synchronous active-low reset (reset beats flush).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef MULTIPLIER_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_ops_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;

    // Saturating counts of result handoffs and output stall cycles.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (out_valid && out_ready && (perf_ops_q != '1)) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if (out_valid && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_multiplier_pipelined.sv
// Self-checking bench for multiplier_pipelined (XLEN=32, DEPTH=2, TAG_W=5).
// Expected results are queued at accept time and compared as results emerge.
module tb_multiplier_pipelined;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef MULTIPLIER_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stall;
`endif

    multiplier_pipelined #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef MULTIPLIER_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   pops    = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: 64-bit products with explicit signedness per op.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        longint      sa;
        longint      sbv;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (op)
            2'b01:   p = 64'(sa * sbv);
            2'b10:   p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Output monitor: every valid output must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output got tag %0d data %h expected no result",
                       out_tag, out_data);
            end
            if (sb.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(sb[0].data));
                chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
                if (out_ready === 1'b1) begin
                    if (lat_chk) chk("latency", 64'(cyc - sb[0].cyc), 64'(DEPTH + 1));
                    void'(sb.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one op and hold it until accepted; queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [4:0] tag, input bit fl, input bit rnd_ready);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        in_valid = 1'b1;
        flush    = fl;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back('{data: model(a, b, op), tag: tag, cyc: cyc});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                flush    = 1'b0;
                if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
                return;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0 && out_valid === 1'b0) break;
            tick(1);
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp1;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef MULTIPLIER_PERF_EN
        chk("rst_perf_ops", 64'(perf_ops), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        rst_n = 1'b1;
        tick(1);

        // Back-to-back ops, fixed latency.
        lat_chk = 1'b1;
        issue(32'd3, 32'd5, 2'b00, 5'd1, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd2, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd3, 1'b0, 1'b0);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd4, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'd2, 2'b00, 5'd5, 1'b0, 1'b0);
        drain();
        chk("const_mul_lo", 64'(model(32'd3, 32'd5, 2'b00)), 64'h0000_000F);

        // Stall with three ops in flight.
        lat_chk = 1'b0;
        issue(32'h0000_1234, 32'h0000_0010, 2'b00, 5'd7, 1'b0, 1'b0);
        issue(32'hDEAD_BEEF, 32'h1234_5678, 2'b01, 5'd8, 1'b0, 1'b0);
        issue(32'hCAFE_F00D, 32'h8765_4321, 2'b11, 5'd9, 1'b0, 1'b0);
        out_ready = 1'b0;
        exp1 = 32'h0001_2340;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_data", 64'(out_data), 64'(exp1));
            chk("stall_out_tag", 64'(out_tag), 64'd7);
            @(posedge clk);
            #1;
        end
        drain();

        // Flush with two in flight plus one accepted in the flush cycle.
        issue(32'd11, 32'd13, 2'b00, 5'd10, 1'b0, 1'b0);
        issue(32'd17, 32'd19, 2'b00, 5'd11, 1'b0, 1'b0);
        issue(32'd23, 32'd29, 2'b00, 5'd12, 1'b1, 1'b0);
        sb.delete();
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            @(negedge clk);
            chk("flush_out_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        lat_chk = 1'b1;
        issue(32'hFFFF_FFFE, 32'd7, 2'b10, 5'd13, 1'b0, 1'b0);
        drain();

        // Reset mid-stream.
        lat_chk = 1'b0;
        issue(32'd100, 32'd200, 2'b00, 5'd14, 1'b0, 1'b0);
        issue(32'd300, 32'd400, 2'b11, 5'd15, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1);
        sb.delete();
        pops = 0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef MULTIPLIER_PERF_EN
        chk("mid_rst_perf_ops", 64'(perf_ops), 64'd0);
        chk("mid_rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
        rst_n = 1'b1;
        tick(1);

        // Random regression with random backpressure and input gaps.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h8000_0000;
                1:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            op = 2'($urandom_range(0, 3));
            issue(a, b, op, 5'($urandom_range(0, 31)), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                tick(1);
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        drain();
`ifdef MULTIPLIER_PERF_EN
        chk("perf_ops_total", 64'(perf_ops), 64'(pops));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
